shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
Parametrised universal shift register. It is the next generation of the fixed 4-stage serial delay line.
- Generalised to WIDTH bits.
- Adds clock enable, hold, bidirectional shift and parallel load, with full parallel readout.
- Adds a shift counter with a one-cycle completion pulse, so it can act as a serializer or deserializer for the serial links in the design.

Parameters:
WIDTH, 4, number of register bits (>= 2)
RST_VAL, 0, value loaded into the register on RESET (WIDTH bits)
CNT_W, $clog2(WIDTH+1), width of the shift counter; derived, not overridden

Ports:
CLK  in  1  rising-edge clock
RESET  in  1  synchronous active-high reset
EN  in  1  clock enable; all state holds when low
MODE  in  2  00 hold, 01 shift right (toward bit 0), 10 shift left (toward bit WIDTH-1), 11 parallel load
SI_MSB  in  1  serial input entering bit WIDTH-1 on shift right
SI_LSB  in  1  serial input entering bit 0 on shift left
PAR_IN  in  WIDTH  parallel load data
PAR_OUT  out  WIDTH  register contents
SO_LSB  out  1  bit 0 of the register (serial out for shift right)
SO_MSB  out  1  bit WIDTH-1 of the register (serial out for shift left)
SHIFT_CNT  out  CNT_W  shifts performed since the last load or reset, saturating at WIDTH
DONE  out  1  one-cycle pulse when SHIFT_CNT reaches WIDTH

Behaviour:
- Interface: single clock CLK; RESET is synchronous and active-high.
- All state updates on the rising edge of CLK. Nothing is asynchronous.
- RESET high at an edge: Q=RST_VAL, SHIFT_CNT=0, DONE=0.
  - RESET has priority over EN and MODE.
  - RESET mid-shift or mid-load aborts the operation with no partial update.
- PAR_OUT=Q, SO_LSB=Q[0], SO_MSB=Q[WIDTH-1]. These are direct register outputs with no combinational path from any input.
- EN=0 (and no RESET): Q and SHIFT_CNT hold; DONE=0.
- EN=1, per MODE:
  - 00 hold: Q and SHIFT_CNT unchanged; DONE=0.
  - 01 shift right: Q <= {SI_MSB, Q[WIDTH-1:1]}.
  - 10 shift left: Q <= {Q[WIDTH-2:0], SI_LSB}.
  - 11 load: Q <= PAR_IN; SHIFT_CNT <= 0; DONE=0.
- Shift count rules (modes 01 and 10):
  - SHIFT_CNT <= SHIFT_CNT+1 if below WIDTH, otherwise it stays at WIDTH (saturating, no wrap).
  - Shift directions may be mixed; both count.
- DONE is registered. It is 1 in exactly the cycle following the edge where SHIFT_CNT goes from WIDTH-1 to WIDTH; otherwise 0.
  - Once saturated, further shifts produce no further DONE until a load or reset.
- Latency:
  - Load is visible on PAR_OUT one cycle after the edge.
  - A serial bit entering via SI_MSB appears on SO_LSB after WIDTH consecutive enabled right shifts.
- Legacy equivalence: with WIDTH=4, EN=1 and MODE=01 held, SO_LSB equals SI_MSB delayed 4 cycles, identical to the legacy 4-stage delay line.
- Unused serial input: SI_LSB is ignored in mode 01 and SI_MSB is ignored in mode 10.
- X on MODE while EN=1 is a protocol violation; the bench flags it.

Test Plan:
- Reset: WIDTH=4, RST_VAL=0, RESET=1 for 2 cycles with EN=1, MODE=11, PAR_IN=1111 -> PAR_OUT=0000, SHIFT_CNT=0, DONE=0.
- Load and serialize right: load 1011, then MODE=01 with SI_MSB=0 for 4 cycles.
  - PAR_OUT=0101,0010,0001,0000.
  - SO_LSB before each shift=1,1,0,1.
  - SHIFT_CNT=1,2,3,4.
  - DONE=1 only in the cycle after the 4th shift; a 5th shift keeps SHIFT_CNT=4 and DONE=0.
- Deserialize left: load 0000, MODE=10 with SI_LSB=1,0,1,1 -> PAR_OUT=0001,0010,0101,1011; DONE pulses once.
- Enable gating: load 1000, shift right twice, EN=0 for 3 cycles with MODE=01 -> PAR_OUT holds 0010 and SHIFT_CNT holds 2; with EN=1 again, 2 more shifts -> DONE pulses.
- Mid-operation events:
  - Load 0110 when SHIFT_CNT=3 -> SHIFT_CNT=0, no DONE.
  - RESET asserted mid-shift -> PAR_OUT=0000 and SHIFT_CNT=0 next cycle, no DONE.
- Legacy/param sweep:
  - WIDTH=4, MODE=01 held, random SI_MSB stream of 32 bits -> SO_LSB equals the stream delayed 4 cycles.
  - Repeat right/left/load checks with WIDTH=8 and RST_VAL=8'hA5.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, bidirectional shift and parallel load over
// WIDTH bits. A saturating shift counter with a one-cycle DONE pulse lets the
// block work as a serializer or deserializer. All outputs come straight from
// flops, so no input has a combinational path to any output.
module shift_reg_univ #(
    parameter int unsigned        WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    localparam int unsigned       CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             SI_MSB,
    input  logic             SI_LSB,
    input  logic [WIDTH-1:0] PAR_IN,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             SO_LSB,
    output logic             SO_MSB,
    output logic [CNT_W-1:0] SHIFT_CNT,
    output logic             DONE
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mode_e            op;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             done;
    logic             done_next;

    assign op = mode_e'(MODE);

    // Counter step for a shift: advances until WIDTH, then sticks there.
    assign cnt_inc = (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);

    // Next-state selection for register, counter and completion pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        q_next    = q;
        cnt_next  = cnt;
        done_next = 1'b0;
        if (EN) begin
            case (op)
                MODE_SHR: begin
                    q_next    = {SI_MSB, q[WIDTH-1:1]};
                    cnt_next  = cnt_inc;
                    done_next = (cnt == CNT_LAST);
                end
                MODE_SHL: begin
                    q_next    = {q[WIDTH-2:0], SI_LSB};
                    cnt_next  = cnt_inc;
                    done_next = (cnt == CNT_LAST);
                end
                MODE_LOAD: begin
                    q_next   = PAR_IN;
                    cnt_next = '0;
                end
                default: begin
                    q_next   = q;
                    cnt_next = cnt;
                end
            endcase
        end
    end

    // State register; synchronous reset wins over enable and mode.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (RESET) begin
            q    <= RST_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            q    <= q_next;
            cnt  <= cnt_next;
            done <= done_next;
        end
    end

    assign PAR_OUT   = q;
    assign SO_LSB    = q[0];
    assign SO_MSB    = q[WIDTH-1];
    assign SHIFT_CNT = cnt;
    assign DONE      = done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: two instances (WIDTH=4/RST_VAL=0 and
// WIDTH=8/RST_VAL=A5). The driver pushes the expected post-edge state into a
// per-instance queue; a monitor pops and compares on every falling edge.
module tb_shift_reg_univ;

    typedef struct {
        logic [7:0] q;
        int         cnt;
        logic       done;
        logic       so_lsb;
        logic       so_msb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_s  [2] = '{1'b0, 1'b0};
    logic       en_s   [2] = '{1'b0, 1'b0};
    logic [1:0] mode_s [2] = '{2'b00, 2'b00};
    logic       smsb_s [2] = '{1'b0, 1'b0};
    logic       slsb_s [2] = '{1'b0, 1'b0};
    logic [7:0] par_s  [2] = '{8'h00, 8'h00};

    logic [3:0] po4;
    logic       sol4, som4, done4;
    logic [2:0] cnt4;
    logic [7:0] po8;
    logic       sol8, som8, done8;
    logic [3:0] cnt8;

    exp_t sbq0[$];
    exp_t sbq1[$];

    // Reference model: plain integer arithmetic on the architectural state.
    logic [7:0] mq [2];
    int         mc [2];
    int         wd [2] = '{4, 8};
    logic [7:0] rv [2] = '{8'h00, 8'hA5};

    bit   legacy = 1'b0;
    bit   hist[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(4), .RST_VAL(4'h0)) dut4 (
        .CLK(clk), .RESET(rst_s[0]), .EN(en_s[0]), .MODE(mode_s[0]),
        .SI_MSB(smsb_s[0]), .SI_LSB(slsb_s[0]), .PAR_IN(par_s[0][3:0]),
        .PAR_OUT(po4), .SO_LSB(sol4), .SO_MSB(som4),
        .SHIFT_CNT(cnt4), .DONE(done4)
    );

    shift_reg_univ #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
        .CLK(clk), .RESET(rst_s[1]), .EN(en_s[1]), .MODE(mode_s[1]),
        .SI_MSB(smsb_s[1]), .SI_LSB(slsb_s[1]), .PAR_IN(par_s[1]),
        .PAR_OUT(po8), .SO_LSB(sol8), .SO_MSB(som8),
        .SHIFT_CNT(cnt8), .DONE(done8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus for instance d. With use_exp the expectation is a
    // hand-derived constant; otherwise it comes from the reference model.
    task automatic step(input int d, input bit rst, input bit en, input logic [1:0] mode,
                        input bit smsb, input bit slsb, input logic [7:0] par,
                        input bit use_exp, input logic [7:0] eq, input int ec, input bit ed);
        int         w;
        logic [7:0] mask;
        bit         mdone;
        exp_t       e;
        w    = wd[d];
        mask = 8'((1 << w) - 1);
        rst_s[d]  = rst;
        en_s[d]   = en;
        mode_s[d] = mode;
        smsb_s[d] = smsb;
        slsb_s[d] = slsb;
        par_s[d]  = par;
        @(posedge clk);
        mdone = 1'b0;
        if (rst) begin
            mq[d] = rv[d];
            mc[d] = 0;
        end else if (en) begin
            if (mode == 2'd1 || mode == 2'd2) begin
                if (mode == 2'd1)
                    mq[d] = (mq[d] >> 1) | (8'(smsb) << (w - 1));
                else
                    mq[d] = ((mq[d] << 1) | 8'(slsb)) & mask;
                mdone = (mc[d] == w - 1);
                mc[d] = (mc[d] < w) ? mc[d] + 1 : w;
            end else if (mode == 2'd3) begin
                mq[d] = par & mask;
                mc[d] = 0;
            end
        end
        if (use_exp) begin
            e.q = eq; e.cnt = ec; e.done = ed;
        end else begin
            e.q = mq[d]; e.cnt = mc[d]; e.done = mdone;
        end
        e.so_lsb = e.q[0];
        e.so_msb = e.q[w-1];
        if (legacy && d == 0) begin
            hist.push_back(smsb);
            e.so_lsb = (hist.size() >= 4) ? hist[hist.size() - 4] : 1'b0;
        end
        if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
        @(negedge clk);
    endtask

    task automatic dstep(input int d, input bit rst, input bit en, input logic [1:0] mode,
                         input bit smsb, input bit slsb, input logic [7:0] par,
                         input logic [7:0] eq, input int ec, input bit ed);
        step(d, rst, en, mode, smsb, slsb, par, 1'b1, eq, ec, ed);
    endtask

    task automatic rstep(input int d, input bit rst, input bit en, input logic [1:0] mode,
                         input bit smsb, input bit slsb, input logic [7:0] par);
        step(d, rst, en, mode, smsb, slsb, par, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic rand_phase(input int d, input int n);
        for (int i = 0; i < n; i++)
            rstep(d, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom));
    endtask

    // Monitor: compare every presented output against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sbq0.size() > 0) begin
            e = sbq0.pop_front();
            check("w4_par_out", 32'(po4), 32'(e.q[3:0]));
            check("w4_shift_cnt", 32'(cnt4), 32'(e.cnt));
            check("w4_done", 32'(done4), 32'(e.done));
            check("w4_so_lsb", 32'(sol4), 32'(e.so_lsb));
            check("w4_so_msb", 32'(som4), 32'(e.so_msb));
        end
        if (sbq1.size() > 0) begin
            e = sbq1.pop_front();
            check("w8_par_out", 32'(po8), 32'(e.q));
            check("w8_shift_cnt", 32'(cnt8), 32'(e.cnt));
            check("w8_done", 32'(done8), 32'(e.done));
            check("w8_so_lsb", 32'(sol8), 32'(e.so_lsb));
            check("w8_so_msb", 32'(som8), 32'(e.so_msb));
        end
    end

    // Protocol watch: MODE must be known whenever EN is high.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en_s[d] === 1'b1 && $isunknown(mode_s[d])) begin
                checks++;
                errors++;
                $display("FAIL mode_x: instance %0d MODE=%b with EN=1", d, mode_s[d]);
            end
        end
    end

    initial begin
        logic [7:0] pat;
        @(negedge clk);

        // WIDTH=4: reset held 2 cycles against a pending load.
        dstep(0, 1, 1, 2'd3, 0, 0, 8'h0F, 8'h0, 0, 0);
        dstep(0, 1, 1, 2'd3, 0, 0, 8'h0F, 8'h0, 0, 0);

        // Load 1011, serialize right with SI_MSB=0, then a 5th saturating shift.
        dstep(0, 0, 1, 2'd3, 0, 0, 8'h0B, 8'hB, 0, 0);
        dstep(0, 0, 1, 2'd1, 0, 1, 8'h00, 8'h5, 1, 0);
        dstep(0, 0, 1, 2'd1, 0, 1, 8'h00, 8'h2, 2, 0);
        dstep(0, 0, 1, 2'd1, 0, 1, 8'h00, 8'h1, 3, 0);
        dstep(0, 0, 1, 2'd1, 0, 1, 8'h00, 8'h0, 4, 1);
        dstep(0, 0, 1, 2'd1, 0, 1, 8'h00, 8'h0, 4, 0);

        // Deserialize left 1,0,1,1 into a cleared register; then hold.
        dstep(0, 0, 1, 2'd3, 0, 0, 8'h00, 8'h0, 0, 0);
        dstep(0, 0, 1, 2'd2, 1, 1, 8'h00, 8'h1, 1, 0);
        dstep(0, 0, 1, 2'd2, 1, 0, 8'h00, 8'h2, 2, 0);
        dstep(0, 0, 1, 2'd2, 1, 1, 8'h00, 8'h5, 3, 0);
        dstep(0, 0, 1, 2'd2, 1, 1, 8'h00, 8'hB, 4, 1);
        dstep(0, 0, 1, 2'd0, 0, 0, 8'h00, 8'hB, 4, 0);

        // Enable gating in the middle of a serialization.
        dstep(0, 0, 1, 2'd3, 0, 0, 8'h08, 8'h8, 0, 0);
        dstep(0, 0, 1, 2'd1, 0, 0, 8'h00, 8'h4, 1, 0);
        dstep(0, 0, 1, 2'd1, 0, 0, 8'h00, 8'h2, 2, 0);
        for (int i = 0; i < 3; i++)
            dstep(0, 0, 0, 2'd1, 1, 1, 8'h0F, 8'h2, 2, 0);
        dstep(0, 0, 1, 2'd1, 0, 0, 8'h00, 8'h1, 3, 0);
        dstep(0, 0, 1, 2'd1, 0, 0, 8'h00, 8'h0, 4, 1);

        // Load at SHIFT_CNT=3 clears the count; reset aborts a shift.
        dstep(0, 0, 1, 2'd3, 0, 0, 8'h0F, 8'hF, 0, 0);
        dstep(0, 0, 1, 2'd1, 1, 0, 8'h00, 8'hF, 1, 0);
        dstep(0, 0, 1, 2'd1, 1, 0, 8'h00, 8'hF, 2, 0);
        dstep(0, 0, 1, 2'd1, 1, 0, 8'h00, 8'hF, 3, 0);
        dstep(0, 0, 1, 2'd3, 0, 0, 8'h06, 8'h6, 0, 0);
        dstep(0, 0, 1, 2'd1, 0, 0, 8'h00, 8'h3, 1, 0);
        dstep(0, 0, 1, 2'd1, 0, 0, 8'h00, 8'h1, 2, 0);
        dstep(0, 0, 1, 2'd1, 0, 0, 8'h00, 8'h0, 3, 0);
        dstep(0, 1, 1, 2'd1, 1, 0, 8'h00, 8'h0, 0, 0);
        dstep(0, 0, 1, 2'd0, 0, 0, 8'h00, 8'h0, 0, 0);

        rand_phase(0, 200);

        // Legacy delay line: MODE=01 held with a random SI_MSB stream.
        rstep(0, 1, 1, 2'd1, 0, 0, 8'h00);
        legacy = 1'b1;
        for (int i = 0; i < 36; i++)
            rstep(0, 0, 1, 2'd1, 1'($urandom), 1'($urandom), 8'($urandom));
        legacy = 1'b0;
        en_s[0] = 1'b0;

        // WIDTH=8, RST_VAL=A5.
        dstep(1, 1, 1, 2'd3, 0, 0, 8'hFF, 8'hA5, 0, 0);
        dstep(1, 0, 1, 2'd3, 0, 0, 8'h3C, 8'h3C, 0, 0);
        dstep(1, 0, 1, 2'd1, 1, 0, 8'h00, 8'h9E, 1, 0);
        dstep(1, 0, 1, 2'd1, 1, 0, 8'h00, 8'hCF, 2, 0);
        dstep(1, 0, 1, 2'd1, 1, 0, 8'h00, 8'hE7, 3, 0);
        dstep(1, 0, 1, 2'd1, 1, 0, 8'h00, 8'hF3, 4, 0);
        dstep(1, 0, 1, 2'd1, 1, 0, 8'h00, 8'hF9, 5, 0);
        dstep(1, 0, 1, 2'd1, 1, 0, 8'h00, 8'hFC, 6, 0);
        dstep(1, 0, 1, 2'd1, 1, 0, 8'h00, 8'hFE, 7, 0);
        dstep(1, 0, 1, 2'd1, 1, 0, 8'h00, 8'hFF, 8, 1);
        dstep(1, 0, 1, 2'd2, 0, 0, 8'h00, 8'hFE, 8, 0);
        dstep(1, 0, 1, 2'd3, 0, 0, 8'h00, 8'h00, 0, 0);
        pat = 8'hC3;
        for (int i = 7; i >= 0; i--)
            rstep(1, 0, 1, 2'd2, 0, pat[i], 8'h00);
        dstep(1, 0, 1, 2'd0, 0, 0, 8'h00, 8'hC3, 8, 0);

        rand_phase(1, 200);
        en_s[1] = 1'b0;

        // Let the monitor drain both scoreboards, bounded.
        for (int i = 0; i < 20 && (sbq0.size() + sbq1.size()) > 0; i++)
            @(negedge clk);
        if ((sbq0.size() + sbq1.size()) > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked", sbq0.size() + sbq1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
